// File: rtl/bin_clock_set_ctrl.sv
// Front-panel time-set controller for the binary clock.
// Buttons are synchronized, debounced and turned into press events; a field
// select FSM (RUN/HOUR/MIN/SEC) then issues single-cycle step pulses toward
// the clock core, with hold-to-repeat, an inactivity timeout and a blink enable.
//
// Press event timing: a raw press sampled high at edge 0 is in the second
// synchronizer stage after edge 1. Debounce samples are taken at edges 2..4,
// and the level rises at edge 4. The press pulse is registered at edge 5, and
// the registered outputs react at edge 6.
//
// Step interface semantics: hour_id_o / minute_id_o / seconds_id_o are
// single-cycle strobes with no back-pressure. Exactly one is high per step,
// and id_switch_o is valid in the same cycle and holds between strobes.
module bin_clock_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_RATE     = 10,
    parameter int TIMEOUT         = 3000,
    parameter int BLINK_HALF      = 50
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       btn_mode_i,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
    output logic       time_set_o,
    output logic       id_switch_o,
    output logic       hour_id_o,
    output logic       minute_id_o,
    output logic       seconds_id_o,
    output logic [1:0] field_o,
    output logic       blink_o
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RP_W    = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam int TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int BL_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RR_LAST = RP_W'(REPEAT_RATE - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

    // Button bit positions in the packed vectors below.
    localparam int B_MODE = 0;
    localparam int B_UP   = 1;
    localparam int B_DOWN = 2;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOUR = 2'd1,
        ST_MIN  = 2'd2,
        ST_SEC  = 2'd3
    } state_t;

    // Input path registers.
    logic [2:0]      btn_raw;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      lvl_q, lvl_d_q;
    logic [2:0]      press_q;
    logic [DB_W-1:0] db_cnt_q [3];

    // Control registers and their next values.
    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [RP_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic            rpt_arm_q, rpt_arm_d;
    logic            rpt_dir_q, rpt_dir_d;
    logic            rpt_first_q, rpt_first_d;
    logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
    logic            blink_q, blink_d;
    logic            id_sw_q;
    logic            hour_q, min_q, sec_q, time_set_q;

    logic fire, fire_dir;
    logic mode_ev, up_ev, dn_ev;
    logic in_set, timed_out, both_held, rpt_held;

    assign btn_raw = {btn_down_i, btn_up_i, btn_mode_i};

    // Two-stage synchronizer, per-button debouncer and rising-edge press detect.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            lvl_d_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            lvl_d_q <= lvl_q;
            press_q <= lvl_q & ~lvl_d_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] != lvl_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        lvl_q[i]    <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign mode_ev   = press_q[B_MODE];
    assign up_ev     = press_q[B_UP];
    assign dn_ev     = press_q[B_DOWN];
    assign in_set    = (state_q != ST_RUN);
    assign timed_out = in_set && (to_cnt_q == TO_LAST);
    assign both_held = lvl_q[B_UP] & lvl_q[B_DOWN];
    assign rpt_held  = rpt_dir_q ? lvl_q[B_UP] : lvl_q[B_DOWN];

    // Next-state, step pulse, repeat, timeout and blink decisions.
    always_comb begin
        state_d     = state_q;
        fire        = 1'b0;
        fire_dir    = id_sw_q;
        rpt_arm_d   = rpt_arm_q;
        rpt_dir_d   = rpt_dir_q;
        rpt_first_d = rpt_first_q;
        rpt_cnt_d   = rpt_cnt_q;
        to_cnt_d    = to_cnt_q;
        bl_cnt_d    = bl_cnt_q;
        blink_d     = blink_q;

        if (!in_set) begin
            // Steps are ignored in RUN; only MODE does anything.
            rpt_arm_d = 1'b0;
            rpt_cnt_d = '0;
            if (mode_ev) state_d = ST_HOUR;
        end else if (timed_out) begin
            // Timeout beats a simultaneous MODE press.
            state_d   = ST_RUN;
            rpt_arm_d = 1'b0;
            rpt_cnt_d = '0;
        end else if (mode_ev) begin
            // MODE beats a simultaneous step event and cancels any repeat.
            unique case (state_q)
                ST_HOUR: state_d = ST_MIN;
                ST_MIN:  state_d = ST_SEC;
                default: state_d = ST_RUN;
            endcase
            rpt_arm_d = 1'b0;
            rpt_cnt_d = '0;
        end else if (both_held) begin
            // Conflicting directions: no steps, repeat held cleared.
            rpt_arm_d = 1'b0;
            rpt_cnt_d = '0;
        end else if (up_ev || dn_ev) begin
            fire        = 1'b1;
            fire_dir    = up_ev;
            rpt_arm_d   = 1'b1;
            rpt_dir_d   = up_ev;
            rpt_first_d = 1'b1;
            rpt_cnt_d   = '0;
        end else if (rpt_arm_q) begin
            if (!rpt_held) begin
                rpt_arm_d = 1'b0;
                rpt_cnt_d = '0;
            end else if (rpt_cnt_q == (rpt_first_q ? RD_LAST : RR_LAST)) begin
                fire        = 1'b1;
                fire_dir    = rpt_dir_q;
                rpt_first_d = 1'b0;
                rpt_cnt_d   = '0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end

        // Inactivity timer: cleared on entry, any press event and any step.
        if (state_d == ST_RUN || state_d != state_q || mode_ev || up_ev || dn_ev || fire) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        // Blink: off in RUN, forced on at entry and on each step.
        if (state_d == ST_RUN) begin
            blink_d  = 1'b0;
            bl_cnt_d = '0;
        end else if (state_d != state_q || fire) begin
            blink_d  = 1'b1;
            bl_cnt_d = '0;
        end else if (bl_cnt_q == BL_LAST) begin
            blink_d  = ~blink_q;
            bl_cnt_d = '0;
        end else begin
            bl_cnt_d = bl_cnt_q + 1'b1;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_RUN;
            to_cnt_q    <= '0;
            rpt_cnt_q   <= '0;
            rpt_arm_q   <= 1'b0;
            rpt_dir_q   <= 1'b0;
            rpt_first_q <= 1'b0;
            bl_cnt_q    <= '0;
            blink_q     <= 1'b0;
            id_sw_q     <= 1'b0;
            hour_q      <= 1'b0;
            min_q       <= 1'b0;
            sec_q       <= 1'b0;
            time_set_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_arm_q   <= rpt_arm_d;
            rpt_dir_q   <= rpt_dir_d;
            rpt_first_q <= rpt_first_d;
            bl_cnt_q    <= bl_cnt_d;
            blink_q     <= blink_d;
            id_sw_q     <= fire_dir;
            hour_q      <= fire && (state_q == ST_HOUR);
            min_q       <= fire && (state_q == ST_MIN);
            sec_q       <= fire && (state_q == ST_SEC);
            time_set_q  <= (state_d != ST_RUN);
        end
    end

    assign field_o      = state_q;
    assign time_set_o   = time_set_q;
    assign id_switch_o  = id_sw_q;
    assign hour_id_o    = hour_q;
    assign minute_id_o  = min_q;
    assign seconds_id_o = sec_q;
    assign blink_o      = blink_q;

endmodule

// File: doc/bin_clock_set_ctrl.md
Name: bin_clock_set_ctrl

Overview:
Front-panel controller that sequences the binary clock's time-set interface from three raw push buttons: MODE, UP and DOWN. It synchronizes and debounces the buttons and runs a field-select state machine (RUN, SET_HOUR, SET_MIN, SET_SEC). In the set states it drives the clock core's time_set, id_switch, hour_id, minute_id and seconds_id inputs as single-cycle step pulses, with hold-to-repeat. It sits between the board I/O pins and the clock core, clocked by the same 100 Hz clk_i.

Parameters:
DEBOUNCE_CYCLES, 3, consecutive stable synchronized samples required to accept a button level change (30 ms at 100 Hz).
REPEAT_DELAY, 50, cycles a step button must stay held after its first pulse before auto-repeat starts.
REPEAT_RATE, 10, cycles between auto-repeat pulses.
TIMEOUT, 3000, cycles without any accepted press in a SET state before forced return to RUN.
BLINK_HALF, 50, half-period of blink_o in cycles.

Ports:
clk_i  in  1  system clock, 100 Hz
reset_i  in  1  asynchronous reset, active-high
btn_mode_i  in  1  raw MODE button, active-high, asynchronous to clk_i
btn_up_i  in  1  raw UP button, active-high, asynchronous
btn_down_i  in  1  raw DOWN button, active-high, asynchronous
time_set_o  out  1  high while in any SET state; drives core time_set
id_switch_o  out  1  step direction: 1 = increment, 0 = decrement
hour_id_o  out  1  one-cycle hour step pulse
minute_id_o  out  1  one-cycle minute step pulse
seconds_id_o  out  1  one-cycle seconds step pulse
field_o  out  2  0 = RUN, 1 = HOUR, 2 = MIN, 3 = SEC
blink_o  out  1  display blink enable for the selected field

Behaviour:
- Reset (reset_i async, active-high; clock clk_i): state RUN; all outputs 0; synchronizers, debounced levels and all counters cleared. Reset mid-press: a button still held at release of reset registers as a new press only after full sync and debounce.
- Input path: each button passes through a 2-FF synchronizer, then a debouncer. The debounced level changes after DEBOUNCE_CYCLES consecutive identical synchronized samples that differ from the current level. Any glitch restarts the count.
- Press event: a rising edge of a debounced level. A raw press held stably produces its event-driven registered output change exactly 2+DEBOUNCE_CYCLES+1 cycles after the first high sample.
- FSM transitions on MODE press: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN. Leaving SET_SEC returns to RUN.
- Timeout: in a SET state, TIMEOUT cycles with no accepted press (any button) forces a return to RUN. The timer resets on every press event and on every state entry.
- All outputs are registered. time_set_o and field_o update in the same cycle as the state register. time_set_o = (state != RUN).
- Step pulses:
  - Only in SET states.
  - An UP press gives one cycle with id_switch_o = 1 and the id line for the current field high.
  - A DOWN press gives the same with id_switch_o = 0.
  - Exactly one id line is high per pulse; all id lines are 0 otherwise.
  - id_switch_o holds its last value between pulses (reset value 0).
  - UP/DOWN presses in RUN are ignored; no pulses ever occur in RUN.
- Auto-repeat:
  - After the first pulse, if the same button stays debounced-high for REPEAT_DELAY cycles, a further pulse is issued, then one every REPEAT_RATE cycles until release.
  - Repeat pulses also reset the timeout timer.
- Simultaneous events:
  - UP and DOWN both debounced-high: no pulses, and the repeat counter is held cleared until both are released.
  - A MODE press in the same cycle as an UP/DOWN event: MODE wins, no step pulse. Repeat is cancelled until the step button is released and pressed again.
  - A MODE press and a timeout in the same cycle: timeout wins (→RUN).
- blink_o:
  - 0 in RUN.
  - In SET states it toggles every BLINK_HALF cycles.
  - It is forced to 1 and its counter restarts on state entry and on every step pulse, so the field is visible while being adjusted.
- Counter widths are sized by $clog2 of each parameter. No counter wraps; each saturates or resets as described.

Test Plan:
- Reset then idle 10 cycles → all outputs 0, field_o = 0. Assert reset_i mid-SET_MIN → immediate RUN, time_set_o = 0.
- Raw MODE high for 2 cycles (glitch) → no state change. MODE held 10 cycles → field_o = 1 and time_set_o = 1 exactly 6 cycles after the first high sample.
- In SET_MIN, UP press held 8 cycles → exactly one minute_id_o pulse with id_switch_o = 1. DOWN press in SET_SEC → one seconds_id_o pulse with id_switch_o = 0.
- In SET_HOUR, UP held 80 cycles → first pulse, second pulse 50 cycles later, third 10 cycles after that; no pulses after release.
- UP and DOWN pressed together in SET_HOUR → zero pulses. UP press in RUN → zero pulses, state unchanged.
- Enter SET_SEC, no activity → at TIMEOUT = 3000 cycles return to RUN, blink_o = 0. Verify blink_o toggles every 50 cycles before the timeout and restarts high after a step pulse.
